// File: rtl/spi_mem_burst_ctrl.sv
// -----------------------------------------------------------------------------
// spi_mem_burst_ctrl
//   Multi-device SPI/QSPI memory controller. Accepts one request from the bus
//   side, selects one of NUM_DEVICES chips, sends command + 24-bit address
//   (plus dummy cycles for quad reads) and then moves burst_len bytes with a
//   per-byte handshake (data_req for writes, rd_valid for reads).
//
//   SCK runs at clock/2 in SPI mode 0. Every SCK period is one low clk and
//   one high clk. Pad outputs change on the clk edge that drives SCK low and
//   pad inputs are sampled on the clk edge that ends the high phase.
//
// Ports
//   clock, reset        system clock, asynchronous active-high reset
//   start               request strobe, only looked at while idle
//   write, quad         direction and lane mode, captured with start
//   dev_sel             chip to address (>= NUM_DEVICES is rejected)
//   address             start byte address, zero-extended to 24 bits
//   burst_len           byte count 1..MAX_BURST (anything else is rejected)
//   bus_data_in         write byte, consumed in the cycle data_req is high
//   data_req            write byte consumed this cycle
//   bus_data_out        most recent read byte (held)
//   rd_valid            bus_data_out updated this cycle
//   busy                transaction in progress
//   op_done_out, error  completion pulse; error marks a rejected request
//   spi_data_in/out/oe  IO[3:0] pad interface with per-lane output enable
//   spi_clk_out         SCK, idles low
//   spi_cs_n            active-low chip selects, at most one low
// -----------------------------------------------------------------------------
module spi_mem_burst_ctrl #(
    parameter int DATA_BUS_WIDTH = 8,
    parameter int ADDRESS_WIDTH  = 16,
    parameter int NUM_DEVICES    = 3,
    parameter int MAX_BURST      = 4,
    parameter int DUMMY_CYCLES   = 4
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             write,
    input  logic                             quad,
    input  logic [$clog2(NUM_DEVICES)-1:0]   dev_sel,
    input  logic [ADDRESS_WIDTH-1:0]         address,
    input  logic [$clog2(MAX_BURST+1)-1:0]   burst_len,
    input  logic [DATA_BUS_WIDTH-1:0]        bus_data_in,
    output logic                             data_req,
    output logic [DATA_BUS_WIDTH-1:0]        bus_data_out,
    output logic                             rd_valid,
    output logic                             busy,
    output logic                             op_done_out,
    output logic                             error,
    input  logic [3:0]                       spi_data_in,
    output logic [3:0]                       spi_data_out,
    output logic [3:0]                       spi_data_oe,
    output logic                             spi_clk_out,
    output logic [NUM_DEVICES-1:0]           spi_cs_n
);

    localparam int DEV_W = $clog2(NUM_DEVICES);
    localparam int BL_W  = $clog2(MAX_BURST + 1);
    localparam int CNT_W = 6;

    localparam logic [DEV_W:0]   DEV_LIM = (DEV_W + 1)'(NUM_DEVICES);
    localparam logic [BL_W-1:0]  BL_MAX  = BL_W'(MAX_BURST);
    localparam logic [BL_W-1:0]  BL_ONE  = BL_W'(1);
    localparam logic [CNT_W-1:0] DUMMY_LAST = CNT_W'(DUMMY_CYCLES - 1);

    // LEAD gives chip select one clk of setup before the first SCK low
    // phase; TAIL holds it one clk after the last sample before DONE.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEAD  = 3'd1,
        ST_CMD   = 3'd2,
        ST_ADDR  = 3'd3,
        ST_DUMMY = 3'd4,
        ST_DATA  = 3'd5,
        ST_TAIL  = 3'd6,
        ST_DONE  = 3'd7
    } state_t;

    // Active-low one-hot-cold select for the requested device.
    function automatic logic [NUM_DEVICES-1:0] cs_decode(input logic [DEV_W-1:0] dev);
        logic [NUM_DEVICES-1:0] cs;
        cs = '1;
        for (int i = 0; i < NUM_DEVICES; i++) begin
            cs[i] = (dev == DEV_W'(i)) ? 1'b0 : 1'b1;
        end
        return cs;
    endfunction

    // Opcode for the four supported transfer kinds.
    function automatic logic [7:0] cmd_byte(input logic wr, input logic qd);
        logic [7:0] c;
        case ({wr, qd})
            2'b00:   c = 8'h03;
            2'b10:   c = 8'h02;
            2'b01:   c = 8'hEB;
            2'b11:   c = 8'h38;
            default: c = 8'h03;
        endcase
        return c;
    endfunction

    // Pad value for the bits at the top of the shift register.
    function automatic logic [3:0] lane_out(input logic [23:0] sh, input logic wide);
        return wide ? sh[23:20] : {3'b000, sh[23]};
    endfunction

    state_t                     state_r, state_s;
    logic                       sck_r, sck_s;
    logic [CNT_W-1:0]           cnt_r, cnt_s;
    logic [BL_W-1:0]            byte_cnt_r, byte_cnt_s;
    logic [23:0]                sh_r, sh_s;
    logic [7:0]                 rx_r, rx_s;
    logic                       write_r, write_s;
    logic                       quad_r, quad_s;
    logic [23:0]                addr_r, addr_s;
    logic [3:0]                 dout_r, dout_s;
    logic [3:0]                 oe_r, oe_s;
    logic [NUM_DEVICES-1:0]     cs_n_r, cs_n_s;
    logic                       busy_r, busy_s;
    logic [DATA_BUS_WIDTH-1:0]  bus_do_r, bus_do_s;
    logic                       data_req_r, data_req_s;
    logic                       rd_valid_r, rd_valid_s;
    logic                       done_r, done_s;
    logic                       err_r, err_s;

    logic                       req_bad_s;
    logic                       wide_s;
    logic [23:0]                sh_shift_s;
    logic [7:0]                 rx_shift_s;
    logic [23:0]                data_sh_s;
    logic [3:0]                 data_dout_s;
    logic [3:0]                 data_oe_s;
    logic [CNT_W-1:0]           data_cnt_s;

    assign req_bad_s = ({1'b0, dev_sel} >= DEV_LIM) || (burst_len == '0) || (burst_len > BL_MAX);

    // Next-state and next-output logic for the transaction sequencer.
    always_comb begin
        state_s    = state_r;
        sck_s      = sck_r;
        cnt_s      = cnt_r;
        byte_cnt_s = byte_cnt_r;
        sh_s       = sh_r;
        rx_s       = rx_r;
        write_s    = write_r;
        quad_s     = quad_r;
        addr_s     = addr_r;
        dout_s     = dout_r;
        oe_s       = oe_r;
        cs_n_s     = cs_n_r;
        busy_s     = busy_r;
        bus_do_s   = bus_do_r;
        data_req_s = 1'b0;
        rd_valid_s = 1'b0;
        done_s     = 1'b0;
        err_s      = 1'b0;

        // The command byte is always single lane even in quad mode.
        wide_s     = quad_r && (state_r != ST_CMD);
        sh_shift_s = wide_s ? {sh_r[19:0], 4'h0} : {sh_r[22:0], 1'b0};
        rx_shift_s = quad_r ? {rx_r[3:0], spi_data_in} : {rx_r[6:0], spi_data_in[1]};

        // First-bit setup for a data byte; the write byte is taken from the
        // bus on the same edge that drives its first bit.
        data_sh_s   = write_r ? {bus_data_in[7:0], 16'h0000} : 24'h000000;
        data_dout_s = lane_out(data_sh_s, quad_r);
        data_oe_s   = quad_r ? (write_r ? 4'b1111 : 4'b0000) : 4'b0001;
        data_cnt_s  = quad_r ? 6'd1 : 6'd7;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (req_bad_s) begin
                        done_s = 1'b1;
                        err_s  = 1'b1;
                    end else begin
                        write_s    = write;
                        quad_s     = quad;
                        addr_s     = 24'(address);
                        byte_cnt_s = burst_len;
                        cs_n_s     = cs_decode(dev_sel);
                        busy_s     = 1'b1;
                        state_s    = ST_LEAD;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LEAD: begin
                sh_s    = {cmd_byte(write_r, quad_r), 16'h0000};
                dout_s  = lane_out({cmd_byte(write_r, quad_r), 16'h0000}, 1'b0);
                oe_s    = 4'b0001;
                cnt_s   = 6'd7;
                sck_s   = 1'b0;
                state_s = ST_CMD;
            end
            ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA: begin
                if (!sck_r) begin
                    sck_s = 1'b1;
                    // Ask for the next write byte during the high phase that
                    // precedes its first bit.
                    data_req_s = write_r && (cnt_r == '0) &&
                                 ((state_r == ST_ADDR) ||
                                  ((state_r == ST_DATA) && (byte_cnt_r != BL_ONE)));
                end else begin
                    sck_s = 1'b0;
                    if ((state_r == ST_DATA) && !write_r) begin
                        rx_s = rx_shift_s;
                    end else begin
                        rx_s = rx_r;
                    end
                    if (cnt_r != '0) begin
                        cnt_s  = cnt_r - 6'd1;
                        sh_s   = sh_shift_s;
                        dout_s = lane_out(sh_shift_s, wide_s);
                    end else begin
                        case (state_r)
                            ST_CMD: begin
                                state_s = ST_ADDR;
                                sh_s    = addr_r;
                                dout_s  = lane_out(addr_r, quad_r);
                                oe_s    = quad_r ? 4'b1111 : 4'b0001;
                                cnt_s   = quad_r ? 6'd5 : 6'd23;
                            end
                            ST_ADDR: begin
                                if (quad_r && !write_r && (DUMMY_CYCLES > 0)) begin
                                    state_s = ST_DUMMY;
                                    sh_s    = 24'h000000;
                                    dout_s  = 4'b0000;
                                    oe_s    = 4'b0000;
                                    cnt_s   = DUMMY_LAST;
                                end else begin
                                    state_s = ST_DATA;
                                    sh_s    = data_sh_s;
                                    dout_s  = data_dout_s;
                                    oe_s    = data_oe_s;
                                    cnt_s   = data_cnt_s;
                                end
                            end
                            ST_DUMMY: begin
                                state_s = ST_DATA;
                                sh_s    = data_sh_s;
                                dout_s  = data_dout_s;
                                oe_s    = data_oe_s;
                                cnt_s   = data_cnt_s;
                            end
                            ST_DATA: begin
                                if (!write_r) begin
                                    bus_do_s   = DATA_BUS_WIDTH'(rx_shift_s);
                                    rd_valid_s = 1'b1;
                                end else begin
                                    bus_do_s   = bus_do_r;
                                end
                                if (byte_cnt_r == BL_ONE) begin
                                    state_s = ST_TAIL;
                                    dout_s  = 4'b0000;
                                    oe_s    = 4'b0000;
                                end else begin
                                    byte_cnt_s = byte_cnt_r - BL_ONE;
                                    state_s    = ST_DATA;
                                    sh_s       = data_sh_s;
                                    dout_s     = data_dout_s;
                                    oe_s       = data_oe_s;
                                    cnt_s      = data_cnt_s;
                                end
                            end
                            default: begin
                                state_s = ST_IDLE;
                            end
                        endcase
                    end
                end
            end
            ST_TAIL: begin
                state_s = ST_DONE;
                cs_n_s  = '1;
                done_s  = 1'b1;
            end
            ST_DONE: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
            end
            default: begin
                state_s = ST_IDLE;
                sck_s   = 1'b0;
                dout_s  = 4'b0000;
                oe_s    = 4'b0000;
                cs_n_s  = '1;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and registered-output update; reset aborts everything at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            sck_r      <= 1'b0;
            cnt_r      <= '0;
            byte_cnt_r <= '0;
            sh_r       <= 24'h000000;
            rx_r       <= 8'h00;
            write_r    <= 1'b0;
            quad_r     <= 1'b0;
            addr_r     <= 24'h000000;
            dout_r     <= 4'b0000;
            oe_r       <= 4'b0000;
            cs_n_r     <= '1;
            busy_r     <= 1'b0;
            bus_do_r   <= '0;
            data_req_r <= 1'b0;
            rd_valid_r <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            sck_r      <= sck_s;
            cnt_r      <= cnt_s;
            byte_cnt_r <= byte_cnt_s;
            sh_r       <= sh_s;
            rx_r       <= rx_s;
            write_r    <= write_s;
            quad_r     <= quad_s;
            addr_r     <= addr_s;
            dout_r     <= dout_s;
            oe_r       <= oe_s;
            cs_n_r     <= cs_n_s;
            busy_r     <= busy_s;
            bus_do_r   <= bus_do_s;
            data_req_r <= data_req_s;
            rd_valid_r <= rd_valid_s;
            done_r     <= done_s;
            err_r      <= err_s;
        end
    end

    assign spi_clk_out  = sck_r;
    assign spi_data_out = dout_r;
    assign spi_data_oe  = oe_r;
    assign spi_cs_n     = cs_n_r;
    assign busy         = busy_r;
    assign bus_data_out = bus_do_r;
    assign data_req     = data_req_r;
    assign rd_valid     = rd_valid_r;
    assign op_done_out  = done_r;
    assign error        = err_r;

endmodule

// File: tb/tb_spi_mem_burst_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_mem_burst_ctrl
//   Directed bench for spi_mem_burst_ctrl with default parameters. A small
//   SPI slave model records pad activity on every SCK rising edge and drives
//   read data on every SCK falling edge; a bus-side model feeds write bytes.
// -----------------------------------------------------------------------------
module tb_spi_mem_burst_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        write;
    logic        quad;
    logic [1:0]  dev_sel;
    logic [15:0] address;
    logic [2:0]  burst_len;
    logic [7:0]  bus_data_in;
    logic        data_req;
    logic [7:0]  bus_data_out;
    logic        rd_valid;
    logic        busy;
    logic        op_done_out;
    logic        error;
    logic [3:0]  spi_data_in = 4'h0;
    logic [3:0]  spi_data_out;
    logic [3:0]  spi_data_oe;
    logic        spi_clk_out;
    logic [2:0]  spi_cs_n;

    spi_mem_burst_ctrl dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .write        (write),
        .quad         (quad),
        .dev_sel      (dev_sel),
        .address      (address),
        .burst_len    (burst_len),
        .bus_data_in  (bus_data_in),
        .data_req     (data_req),
        .bus_data_out (bus_data_out),
        .rd_valid     (rd_valid),
        .busy         (busy),
        .op_done_out  (op_done_out),
        .error        (error),
        .spi_data_in  (spi_data_in),
        .spi_data_out (spi_data_out),
        .spi_data_oe  (spi_data_oe),
        .spi_clk_out  (spi_clk_out),
        .spi_cs_n     (spi_cs_n)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- SPI slave model ----------------
    int         sck_cnt    = 0;
    int         sck_base   = 0;
    int         data_start = 0;
    logic       quad_mode  = 1'b0;
    logic [7:0] resp [4];
    logic [3:0] io_cap [512];
    logic [3:0] oe_cap [512];

    function automatic logic [3:0] resp_lanes(input int k);
        int j;
        logic [7:0] b;
        if (k < data_start) return 4'h0;
        j = k - data_start;
        if (quad_mode) begin
            b = resp[(j / 2) & 3];
            return ((j % 2) == 0) ? b[7:4] : b[3:0];
        end
        b = resp[(j / 8) & 3];
        return {2'b00, b[7 - (j % 8)], 1'b0};
    endfunction

    always @(posedge spi_clk_out) begin
        io_cap[sck_cnt % 512] = spi_data_out;
        oe_cap[sck_cnt % 512] = spi_data_oe;
        sck_cnt = sck_cnt + 1;
    end

    always @(negedge spi_clk_out) begin
        spi_data_in = resp_lanes(sck_cnt - sck_base);
    end

    function automatic logic [31:0] io0_bits(input int first, input int n);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v = {v[30:0], io_cap[(sck_base + first + i) % 512][0]};
        return v;
    endfunction

    function automatic logic [31:0] nibs(input int first, input int n);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v = {v[27:0], io_cap[(sck_base + first + i) % 512]};
        return v;
    endfunction

    // ---------------- bus-side write data ----------------
    logic [7:0] wr_bytes [4];
    int         wr_cnt  = 0;
    int         wr_base = 0;

    always @(posedge clock) begin
        if (data_req) wr_cnt <= wr_cnt + 1;
    end

    assign bus_data_in = wr_bytes[(wr_cnt - wr_base) & 3];

    // ---------------- transaction driver / monitor ----------------
    int         n_done, n_err, n_rdv, n_dreq, done_at, busy_seen;
    logic [2:0] cs_seen;
    logic [7:0] rd_got [4];
    logic       timed_out;

    task automatic do_txn(input logic w, input logic q, input logic [1:0] dev,
                          input logic [15:0] a, input logic [2:0] len,
                          input int pulse_at, input int budget);
        int cyc;
        @(negedge clock);
        write = w; quad = q; dev_sel = dev; address = a; burst_len = len; start = 1'b1;
        sck_base = sck_cnt; wr_base = wr_cnt;
        n_done = 0; n_err = 0; n_rdv = 0; n_dreq = 0; done_at = -1; busy_seen = 0;
        cs_seen = 3'b000; timed_out = 1'b1;
        for (int i = 0; i < 4; i++) rd_got[i] = 8'h00;
        cyc = 0;
        while (cyc < budget) begin
            @(negedge clock);
            cyc++;
            start = (cyc == pulse_at);
            if (cyc == pulse_at) begin
                write = ~w; quad = ~q; dev_sel = 2'd1; address = 16'hBEEF; burst_len = 3'd2;
            end
            if (op_done_out) begin n_done++; done_at = cyc; end
            if (error) n_err++;
            if (rd_valid) begin
                if (n_rdv < 4) rd_got[n_rdv] = bus_data_out;
                n_rdv++;
            end
            if (data_req) n_dreq++;
            if (busy) busy_seen++;
            cs_seen = cs_seen | ~spi_cs_n;
            if ((n_done != 0) && !busy && !op_done_out) begin
                timed_out = 1'b0;
                break;
            end
        end
        start = 1'b0;
        check_val("no_timeout", 32'(timed_out), 32'd0);
    endtask

    int late_done;

    initial begin
        reset = 1'b1; start = 1'b0; write = 1'b0; quad = 1'b0;
        dev_sel = 2'd0; address = 16'h0000; burst_len = 3'd0;
        for (int i = 0; i < 4; i++) begin resp[i] = 8'h00; wr_bytes[i] = 8'h00; end
        repeat (3) @(negedge clock);

        // Reset state
        check_val("rst_cs_n", 32'(spi_cs_n), 32'h7);
        check_val("rst_pads", 32'({spi_clk_out, spi_data_oe, spi_data_out}), 32'h0);
        check_val("rst_flags", 32'({busy, data_req, rd_valid, op_done_out, error}), 32'h0);
        check_val("rst_bus_out", 32'(bus_data_out), 32'h0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // Single read dev 0, 0x1234, 1 byte, slave returns 0xA5
        quad_mode = 1'b0; data_start = 32; resp[0] = 8'hA5;
        do_txn(1'b0, 1'b0, 2'd0, 16'h1234, 3'd1, -1, 200);
        check_val("sr_cmd", io0_bits(0, 8), 32'h03);
        check_val("sr_addr", io0_bits(8, 24), 32'h001234);
        check_val("sr_addr_oe", 32'(oe_cap[(sck_base + 8) % 512]), 32'h1);
        check_val("sr_rdv_cnt", 32'(n_rdv), 32'd1);
        check_val("sr_rd_byte", 32'(rd_got[0]), 32'hA5);
        check_val("sr_bus_hold", 32'(bus_data_out), 32'hA5);
        check_val("sr_sck_cnt", 32'(sck_cnt - sck_base), 32'd40);
        check_val("sr_done_cnt", 32'(n_done), 32'd1);
        check_val("sr_latency", 32'(done_at), 32'd83);
        check_val("sr_err", 32'(n_err), 32'd0);
        check_val("sr_cs", 32'(cs_seen), 32'h1);

        // Quad write dev 2, 0xFFFF, bytes 11 22 33 44
        wr_bytes[0] = 8'h11; wr_bytes[1] = 8'h22; wr_bytes[2] = 8'h33; wr_bytes[3] = 8'h44;
        quad_mode = 1'b1; data_start = 1000;
        do_txn(1'b1, 1'b1, 2'd2, 16'hFFFF, 3'd4, -1, 200);
        check_val("qw_cmd", io0_bits(0, 8), 32'h38);
        check_val("qw_cmd_oe", 32'(oe_cap[sck_base % 512]), 32'h1);
        check_val("qw_addr", nibs(8, 6), 32'h00FFFF);
        check_val("qw_addr_oe", 32'(oe_cap[(sck_base + 8) % 512]), 32'hF);
        check_val("qw_data", nibs(14, 8), 32'h11223344);
        check_val("qw_dreq_cnt", 32'(n_dreq), 32'd4);
        check_val("qw_cs", 32'(cs_seen), 32'h4);
        check_val("qw_sck_cnt", 32'(sck_cnt - sck_base), 32'd22);
        check_val("qw_latency", 32'(done_at), 32'd47);

        // Quad read dev 1, 0x0042, 2 bytes 5A C3
        quad_mode = 1'b1; data_start = 18; resp[0] = 8'h5A; resp[1] = 8'hC3;
        do_txn(1'b0, 1'b1, 2'd1, 16'h0042, 3'd2, -1, 200);
        check_val("qr_cmd", io0_bits(0, 8), 32'hEB);
        check_val("qr_addr", nibs(8, 6), 32'h000042);
        check_val("qr_dummy_oe", 32'(oe_cap[(sck_base + 14) % 512] | oe_cap[(sck_base + 15) % 512] |
                                     oe_cap[(sck_base + 16) % 512] | oe_cap[(sck_base + 17) % 512]), 32'h0);
        check_val("qr_data_oe", 32'(oe_cap[(sck_base + 18) % 512]), 32'h0);
        check_val("qr_rdv_cnt", 32'(n_rdv), 32'd2);
        check_val("qr_byte0", 32'(rd_got[0]), 32'h5A);
        check_val("qr_byte1", 32'(rd_got[1]), 32'hC3);
        check_val("qr_sck_cnt", 32'(sck_cnt - sck_base), 32'd22);
        check_val("qr_cs", 32'(cs_seen), 32'h2);

        // Reject: dev_sel out of range
        do_txn(1'b0, 1'b0, 2'd3, 16'h0010, 3'd1, -1, 20);
        check_val("rej_dev_done", 32'(n_done), 32'd1);
        check_val("rej_dev_err", 32'(n_err), 32'd1);
        check_val("rej_dev_when", 32'(done_at), 32'd1);
        check_val("rej_dev_busy", 32'(busy_seen), 32'd0);
        check_val("rej_dev_cs", 32'(cs_seen), 32'h0);
        check_val("rej_dev_sck", 32'(sck_cnt - sck_base), 32'd0);

        // Reject: zero-length burst, then over-long burst
        do_txn(1'b1, 1'b0, 2'd0, 16'h0010, 3'd0, -1, 20);
        check_val("rej_len0_err", 32'(n_err), 32'd1);
        check_val("rej_len0_cs", 32'({cs_seen, 5'(busy_seen)}), 32'h0);
        do_txn(1'b0, 1'b1, 2'd1, 16'h0010, 3'd5, -1, 20);
        check_val("rej_len5_err", 32'(n_err), 32'd1);
        check_val("rej_len5_sck", 32'(sck_cnt - sck_base), 32'd0);

        // start pulsed while busy is ignored
        quad_mode = 1'b0; data_start = 32; resp[0] = 8'h3C;
        do_txn(1'b0, 1'b0, 2'd0, 16'h1234, 3'd1, 10, 200);
        check_val("bz_done_cnt", 32'(n_done), 32'd1);
        check_val("bz_latency", 32'(done_at), 32'd83);
        check_val("bz_cs", 32'(cs_seen), 32'h1);
        check_val("bz_cmd", io0_bits(0, 8), 32'h03);
        check_val("bz_rd_byte", 32'(rd_got[0]), 32'h3C);
        check_val("bz_sck_cnt", 32'(sck_cnt - sck_base), 32'd40);
        check_val("bz_err", 32'(n_err), 32'd0);

        // Reset in the middle of the address phase
        @(negedge clock);
        write = 1'b0; quad = 1'b0; dev_sel = 2'd0; address = 16'h1234; burst_len = 3'd1; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (28) @(negedge clock);
        check_val("mid_cs_active", 32'(spi_cs_n), 32'h6);
        check_val("mid_oe_active", 32'(spi_data_oe), 32'h1);
        reset = 1'b1;
        #1;
        check_val("mid_rst_cs", 32'(spi_cs_n), 32'h7);
        check_val("mid_rst_pads", 32'({spi_clk_out, spi_data_oe}), 32'h0);
        check_val("mid_rst_busy", 32'(busy), 32'd0);
        late_done = 0;
        repeat (2) begin
            @(negedge clock);
            if (op_done_out) late_done++;
        end
        reset = 1'b0;
        repeat (6) begin
            @(negedge clock);
            if (op_done_out) late_done++;
        end
        check_val("mid_rst_no_done", 32'(late_done), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
